// File: rtl/spm_feeder.sv
// spm_feeder: wakes the SPM, sends its header, streams samples and collects per-interval min/max results
module spm_feeder #(
  parameter logic [15:0] SYNC_WORD   = 16'hA5A5,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] cfg_total_samples,
  input  logic [31:0] cfg_samples_per_interval,
  input  logic [15:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [15:0] spm_data_in,
  output logic        spm_data_in_available,
  input  logic        spm_data_in_ready,
  input  logic [15:0] spm_data_out,
  output logic        spm_data_out_available,
  input  logic        spm_data_out_ready,
  output logic [15:0] res_min,
  output logic [15:0] res_max,
  output logic [15:0] res_index,
  output logic        res_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [3:0] {IDLE, WAKE, HDR_SEND, HDR_ACK, SRC_WAIT, S_SEND, S_ACK, COLLECT, ERROR} state_t;
  state_t state_q, state_d;
  logic [31:0] total_q, total_d, len_q, len_d, samp_q, samp_d, ivc_q, ivc_d;
  logic [15:0] sample_q, sample_d, min_q, min_d, max_q, max_d, idx_q, idx_d, icnt_q, icnt_d;
  logic [2:0]  hdr_q, hdr_d;
  logic [1:0]  col_q, col_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
  logic [15:0] hdr_word;
  logic        last, tmo_hit, total_done;
  assign hdr_word = hdr_q == 3'd0 ? SYNC_WORD : hdr_q == 3'd1 ? total_q[15:0] : hdr_q == 3'd2 ? total_q[31:16] :
                    hdr_q == 3'd3 ? len_q[15:0] : hdr_q == 3'd4 ? len_q[31:16] : 16'h0000;
  assign total_done = samp_q == total_q;
  assign last       = ivc_q == len_q || total_done;
  assign tmo_hit    = tmo_q + 8'd1 == 8'(ACK_TIMEOUT);
  // next-state and datapath updates for the handshake sequencer
  always_comb begin
    state_d = state_q; total_d = total_q; len_d = len_q; samp_d = samp_q; ivc_d = ivc_q;
    sample_d = sample_q; min_d = min_q; max_d = max_q; idx_d = idx_q; icnt_d = icnt_q;
    hdr_d = hdr_q; col_d = col_q; tmo_d = tmo_q; err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        total_d = cfg_total_samples;
        len_d   = (cfg_samples_per_interval != 0 && cfg_samples_per_interval <= cfg_total_samples) ?
                  cfg_samples_per_interval : cfg_total_samples;
        samp_d  = '0; ivc_d = '0; icnt_d = '0;
        err_d   = cfg_total_samples == 0;
        state_d = cfg_total_samples == 0 ? ERROR : WAKE;
      end
      WAKE: begin
        hdr_d   = '0;
        state_d = HDR_SEND;
      end
      HDR_SEND: begin
        tmo_d   = '0;
        state_d = HDR_ACK;
      end
      HDR_ACK: if (spm_data_in_ready) begin
        hdr_d   = hdr_q + 3'd1;
        state_d = hdr_q == 3'd5 ? SRC_WAIT : HDR_SEND;
      end else begin
        tmo_d   = tmo_q + 8'd1;
        err_d   = err_q | tmo_hit;
        state_d = tmo_hit ? ERROR : HDR_ACK;
      end
      SRC_WAIT: if (src_valid) begin
        sample_d = src_data;
        samp_d   = samp_q + 32'd1;
        ivc_d    = ivc_q + 32'd1;
        state_d  = S_SEND;
      end
      S_SEND: begin
        tmo_d   = '0;
        col_d   = '0;
        state_d = last ? COLLECT : S_ACK;
      end
      S_ACK: if (spm_data_in_ready) state_d = SRC_WAIT;
      else begin
        tmo_d   = tmo_q + 8'd1;
        err_d   = err_q | tmo_hit;
        state_d = tmo_hit ? ERROR : S_ACK;
      end
      COLLECT: if (col_q == 2'd2) begin
        icnt_d  = icnt_q + 16'd1;
        ivc_d   = '0;
        state_d = total_done ? IDLE : SRC_WAIT;
      end else if (spm_data_out_ready) begin
        col_d = col_q + 2'd1;
        tmo_d = '0;
        min_d = col_q == 2'd0 ? spm_data_out : min_q;
        max_d = col_q == 2'd1 ? spm_data_out : max_q;
        idx_d = col_q == 2'd1 ? icnt_q : idx_q;
      end else begin
        tmo_d   = tmo_q + 8'd1;
        err_d   = err_q | tmo_hit;
        state_d = tmo_hit ? ERROR : COLLECT;
      end
      default: state_d = ERROR;
    endcase
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE; total_q <= '0; len_q <= '0; samp_q <= '0; ivc_q <= '0;
      sample_q <= '0; min_q <= '0; max_q <= '0; idx_q <= '0; icnt_q <= '0;
      hdr_q <= '0; col_q <= '0; tmo_q <= '0; err_q <= 1'b0;
    end else begin
      state_q <= state_d; total_q <= total_d; len_q <= len_d; samp_q <= samp_d; ivc_q <= ivc_d;
      sample_q <= sample_d; min_q <= min_d; max_q <= max_d; idx_q <= idx_d; icnt_q <= icnt_d;
      hdr_q <= hdr_d; col_q <= col_d; tmo_q <= tmo_d; err_q <= err_d;
    end
  end
  assign spm_data_in_available  = state_q == WAKE || state_q == HDR_SEND || state_q == S_SEND;
  assign spm_data_in            = state_q == WAKE ? SYNC_WORD : state_q == HDR_SEND ? hdr_word :
                                  state_q == S_SEND ? sample_q : 16'h0000;
  assign src_ready              = state_q == SRC_WAIT;
  assign spm_data_out_available = state_q == COLLECT;
  assign res_valid              = state_q == COLLECT && col_q == 2'd2;
  assign done                   = res_valid && total_done;
  assign busy                   = state_q != IDLE && state_q != ERROR;
  assign err                    = err_q;
  assign res_min                = min_q;
  assign res_max                = max_q;
  assign res_index              = idx_q;
endmodule

// File: tb/tb_spm_feeder.sv
// tb_spm_feeder: scoreboard bench with an SPM responder for spm_feeder
module tb_spm_feeder;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] cfg_total_samples = '0, cfg_samples_per_interval = '0;
  logic [15:0] src_data = '0;
  logic        src_valid = 1'b0, src_ready;
  logic [15:0] spm_data_in;
  logic        spm_data_in_available, spm_data_in_ready = 1'b0;
  logic [15:0] spm_data_out = '0;
  logic        spm_data_out_available, spm_data_out_ready = 1'b0;
  logic [15:0] res_min, res_max, res_index;
  logic        res_valid, busy, done, err;

  spm_feeder dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_total_samples(cfg_total_samples), .cfg_samples_per_interval(cfg_samples_per_interval),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .spm_data_in(spm_data_in), .spm_data_in_available(spm_data_in_available), .spm_data_in_ready(spm_data_in_ready),
    .spm_data_out(spm_data_out), .spm_data_out_available(spm_data_out_available), .spm_data_out_ready(spm_data_out_ready),
    .res_min(res_min), .res_max(res_max), .res_index(res_index), .res_valid(res_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] w; bit ack;} word_t;
  typedef struct {logic [15:0] mn, mx, idx; bit dn;} res_t;
  word_t       wq[$];
  res_t        resq[$];
  logic [31:0] pairq[$];
  int          n_chk = 0, n_pass = 0;
  bit          ack_pend = 0, withhold_max = 0;
  int          rphase = 0, av_cnt = 0, words_seen = 0, done_seen = 0;
  logic [15:0] smp [8];
  logic [31:0] prs [8];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // SPM responder and scoreboard monitor, sampling away from the active edge
  always @(negedge clk) begin : mon
    word_t w;
    res_t  r;
    logic [31:0] p;
    if (reset) begin
      ack_pend = 0; rphase = 0; av_cnt = 0;
      spm_data_in_ready = 1'b0; spm_data_out_ready = 1'b0;
    end else begin
      spm_data_in_ready = ack_pend;
      ack_pend = 0;
      if (spm_data_in_available) begin
        words_seen++;
        if (wq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_word: got %h expected none", spm_data_in);
        end else begin
          w = wq.pop_front();
          chk("spm_word", 64'(spm_data_in), 64'(w.w));
          ack_pend = w.ack;
        end
      end
      if (spm_data_out_available) begin
        av_cnt++;
        if (rphase == 0 && pairq.size() > 0) begin
          p = pairq[0]; spm_data_out = p[31:16]; spm_data_out_ready = 1'b1; rphase = 1;
        end else if (rphase == 1 && !withhold_max) begin
          p = pairq.pop_front(); spm_data_out = p[15:0]; spm_data_out_ready = 1'b1; rphase = 2;
        end else spm_data_out_ready = 1'b0;
      end else begin
        if (av_cnt != 0) chk("out_avail_edges", 64'(av_cnt), 64'd3);
        av_cnt = 0; rphase = 0; spm_data_out_ready = 1'b0;
      end
      if (res_valid) begin
        if (resq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_result: got min %h max %h expected none", res_min, res_max);
        end else begin
          r = resq.pop_front();
          chk("res_min", 64'(res_min), 64'(r.mn));
          chk("res_max", 64'(res_max), 64'(r.mx));
          chk("res_index", 64'(res_index), 64'(r.idx));
          chk("done_with_result", 64'(done), 64'(r.dn));
        end
      end else if (done) begin
        n_chk++;
        $display("FAIL done_without_result: got done 1 expected 0");
      end
      if (done) done_seen++;
    end
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start(logic [31:0] total, logic [31:0] spi);
    @(negedge clk);
    cfg_total_samples = total; cfg_samples_per_interval = spi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!src_ready && t < 200) begin @(negedge clk); t++; end
    chk("src_ready_seen", 64'(src_ready), 64'd1);
  endtask

  task automatic send(logic [15:0] d);
    src_valid = 1'b1; src_data = d;
    wait_ready();
    @(negedge clk);
    src_valid = 1'b0;
  endtask

  task automatic push_header(logic [31:0] total, logic [31:0] len, int n_hdr, bit ack_last);
    logic [15:0] h [6];
    h = '{16'hA5A5, total[15:0], total[31:16], len[15:0], len[31:16], 16'h0000};
    wq.push_back('{16'hA5A5, 1'b0});
    for (int i = 0; i < n_hdr; i++) wq.push_back('{h[i], (i == n_hdr - 1) ? ack_last : 1'b1});
  endtask

  task automatic run(int total, int spi, int stall_after);
    int L, iv, r, d0, t, w0;
    bit last;
    L = (spi != 0 && spi <= total) ? spi : total;
    push_header(total, L, 6, 1'b1);
    iv = 0; r = 0;
    for (int i = 0; i < total; i++) begin
      iv++;
      last = iv == L || i + 1 == total;
      wq.push_back('{smp[i], !last});
      if (last) begin
        resq.push_back('{prs[r][31:16], prs[r][15:0], 16'(r), i + 1 == total});
        pairq.push_back(prs[r]);
        r++; iv = 0;
      end
    end
    d0 = done_seen;
    pulse_start(total, spi);
    for (int i = 0; i < total; i++) begin
      send(smp[i]);
      if (i == stall_after) begin
        wait_ready();
        w0 = words_seen;
        repeat (10) @(negedge clk);
        chk("stall_no_words", 64'(words_seen), 64'(w0));
        chk("stall_no_err", 64'(err), 64'd0);
        chk("stall_src_ready", 64'(src_ready), 64'd1);
      end
    end
    t = 0;
    while (done_seen == d0 && t < 300) begin @(negedge clk); t++; end
    chk("done_pulse", 64'(done_seen - d0), 64'd1);
    repeat (2) @(negedge clk);
    chk("words_drained", 64'(wq.size()), 64'd0);
    chk("results_drained", 64'(resq.size()), 64'd0);
    chk("run_err", 64'(err), 64'd0);
    chk("run_idle", 64'(busy), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t, w0;
    repeat (3) @(negedge clk);
    chk("rst_words", {res_min, res_max, res_index, spm_data_in}, 64'd0);
    chk("rst_flags", {src_ready, spm_data_in_available, spm_data_out_available, res_valid, busy, done, err}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    smp = '{16'h0010, 16'h0020, 16'h0005, 16'h0030, 16'h0, 16'h0, 16'h0, 16'h0};
    prs = '{32'h0010_0020, 32'h0005_0030, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run(4, 2, -1);

    smp = '{16'h0007, 16'h0003, 16'h0009, 16'h0001, 16'h0008, 16'h0, 16'h0, 16'h0};
    prs = '{32'h0003_0007, 32'h0001_0009, 32'h0008_0008, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run(5, 2, -1);

    prs = '{32'h0001_0009, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run(5, 0, -1);

    smp = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0, 16'h0, 16'h0, 16'h0};
    prs = '{32'h0001_0004, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run(4, 4, 1);

    push_header(32'd4, 32'd2, 3, 1'b0);
    w0 = words_seen;
    pulse_start(32'd4, 32'd2);
    t = 0;
    while (words_seen < w0 + 4 && t < 100) begin @(negedge clk); t++; end
    chk("tmo_words_sent", 64'(words_seen - w0), 64'd4);
    repeat (12) @(negedge clk);
    chk("tmo_not_yet", 64'(err), 64'd0);
    repeat (8) @(negedge clk);
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_quiet", {src_ready, spm_data_in_available, spm_data_out_available, res_valid, busy, done}, 64'd0);
    w0 = words_seen;
    pulse_start(32'd4, 32'd2);
    repeat (5) @(negedge clk);
    chk("err_start_ignored", {busy, err}, 64'b01);
    chk("err_no_words", 64'(words_seen), 64'(w0));
    do_reset();
    chk("err_cleared", 64'(err), 64'd0);

    push_header(32'd2, 32'd2, 6, 1'b1);
    wq.push_back('{16'h0011, 1'b1});
    wq.push_back('{16'h0022, 1'b0});
    pairq.push_back(32'h0011_0022);
    withhold_max = 1;
    pulse_start(32'd2, 32'd2);
    send(16'h0011);
    send(16'h0022);
    t = 0;
    while (res_min != 16'h0011 && t < 50) begin @(negedge clk); t++; end
    chk("collect_min", 64'(res_min), 64'h11);
    chk("collect_avail", 64'(spm_data_out_available), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_words", {res_min, res_max, res_index, spm_data_in}, 64'd0);
    chk("rst_mid_flags", {src_ready, spm_data_in_available, spm_data_out_available, res_valid, busy, done, err}, 64'd0);
    reset = 1'b0;
    withhold_max = 0;
    pairq.delete();
    resq.delete();
    @(negedge clk);
    smp = '{16'h0042, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    prs = '{32'h0042_0042, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run(1, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
